// File: rtl/system_switch_pkg.sv
// Shared constants and helpers for the slide-switch debounce block.
//   DEBOUNCE_TICK_DIV_DEFAULT     : clk cycles per debounce tick (1 ms at 50 MHz)
//   DEBOUNCE_STABLE_TICKS_DEFAULT : consecutive mismatched ticks before a commit
//   clog2_min1(n)                 : max(1, $clog2(n)), a counter width that is never zero
package system_switch_pkg;

  localparam int DEBOUNCE_TICK_DIV_DEFAULT     = 50000;
  localparam int DEBOUNCE_STABLE_TICKS_DEFAULT = 10;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/system_switch_debounce_bit.sv
// One switch bit: 2-flop synchroniser, tick-driven stability counter,
// debounced level and one-cycle rise/fall pulses.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   tick       : shared prescaler strobe, high for one cycle per debounce tick
//   raw        : asynchronous switch pin
//   init       : value loaded into the synchroniser and sw_out on reset
//   sw_out     : debounced level
//   rise, fall : registered one-cycle pulses on a committed 0->1 / 1->0
//   commit     : combinational, high in the cycle whose edge commits a new level
import system_switch_pkg::*;

module system_switch_debounce_bit #(
  parameter int STABLE_TICKS = DEBOUNCE_STABLE_TICKS_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  input  logic init,
  output logic sw_out,
  output logic rise,
  output logic fall,
  output logic commit
);

  localparam int               CNT_W    = clog2_min1(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;

  // stage 0/1: two-flop synchroniser into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= init;
      sync_p1 <= init;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  assign mismatch = sync_p1 ^ sw_out;
  assign commit   = mismatch & tick & (cnt == CNT_LAST);

  // stage 2: stability counter; any matching cycle restarts the window
  generate
    if (STABLE_TICKS == 1) begin : g_no_cnt
      assign cnt = '0;
    end else begin : g_cnt
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt <= '0;
        end else if (!mismatch || commit) begin
          cnt <= '0;
        end else if (tick) begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  endgenerate

  // stage 3: committed level and pulses, all updated on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_out <= init;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      if (commit) sw_out <= sync_p1;
      rise <= commit &  sync_p1;
      fall <= commit & ~sync_p1;
    end
  end

endmodule

// File: rtl/system_switch_debounce.sv
// Debounces WIDTH raw slide-switch pins for the switch PIO in_port.
// A free-running prescaler produces a tick every TICK_DIV cycles; each bit
// commits a new level after STABLE_TICKS consecutive mismatched ticks.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   sw_raw     : asynchronous switch pins
//   sw_out     : debounced level bus
//   rise, fall : one-cycle pulses per bit on committed edges
//   changed    : one-cycle pulse, |(rise|fall), registered
import system_switch_pkg::*;

module system_switch_debounce #(
  parameter int               WIDTH        = 8,
  parameter int               TICK_DIV     = DEBOUNCE_TICK_DIV_DEFAULT,
  parameter int               STABLE_TICKS = DEBOUNCE_STABLE_TICKS_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int               DIV_W    = clog2_min1(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [WIDTH-1:0] commit;

  // prescaler: free-running, never restarted by switch activity
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    system_switch_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .raw    (sw_raw[i]),
      .init   (RESET_VALUE[i]),
      .sw_out (sw_out[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .commit (commit[i])
    );
  end

  // changed is registered from the same commit strobes that load rise/fall,
  // so it is high in exactly the cycle any rise/fall pulse is high
  always_ff @(posedge clk) begin
    if (reset) begin
      changed <= 1'b0;
    end else begin
      changed <= |commit;
    end
  end

endmodule

// File: tb/tb_system_switch_debounce.sv
// Scoreboard bench for system_switch_debounce (TICK_DIV=4, STABLE_TICKS=3).
// Stimulus pushes each expected commit (pulses, level, cycle window) into a
// queue; a negedge monitor pops and compares whenever a pulse appears, and
// tracks the expected debounced level every cycle.
module tb_system_switch_debounce;

  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] lvl;
    int         lo;
    int         hi;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_err    = 0;
  exp_t q[$];
  exp_t e;
  logic [7:0] lvl = 8'h00;

  system_switch_debounce #(
    .WIDTH       (WIDTH),
    .TICK_DIV    (4),
    .STABLE_TICKS(3),
    .RESET_VALUE (8'h00)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sw_raw (sw_raw),
    .sw_out (sw_out),
    .rise   (rise),
    .fall   (fall),
    .changed(changed)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic drive(input logic [7:0] val);
    @(posedge clk);
    #1 sw_raw = val;
  endtask

  // Drive a new value and register the commit it must produce 11..14 cycles later.
  task automatic step(input logic [7:0] val, input logic [7:0] r,
                      input logic [7:0] f, input logic [7:0] l);
    exp_t x;
    drive(val);
    x.rise = r; x.fall = f; x.lvl = l; x.lo = cyc + 11; x.hi = cyc + 14;
    q.push_back(x);
  endtask

  task automatic settle(input string name);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk(name, 32'(q.size()), 32'd0);
  endtask

  // monitor
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      lvl = 8'h00;
    end else if (reset === 1'b0) begin
      if (changed !== 1'b0 || rise !== 8'h00 || fall !== 8'h00) begin
        if (q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_pulse at cycle %0d: rise=%0h fall=%0h changed=%0b, expected no pulse",
                   cyc, rise, fall, changed);
        end else begin
          e = q.pop_front();
          chk("rise",    32'(rise),    32'(e.rise));
          chk("fall",    32'(fall),    32'(e.fall));
          chk("changed", 32'(changed), 32'd1);
          chk("commit_level", 32'(sw_out), 32'(e.lvl));
          n_checks++;
          if (cyc < e.lo || cyc > e.hi) begin
            n_err++;
            $display("FAIL commit_cycle: got cycle %0d, expected %0d..%0d", cyc, e.lo, e.hi);
          end
          lvl = e.lvl;
        end
      end
      chk("level", 32'(sw_out), 32'(lvl));
    end
  end

  initial begin
    reset  = 1'b1;
    sw_raw = 8'hFF;

    // reset held 3 cycles with all pins high
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset_out",   32'(sw_out), 32'h00);
      chk("reset_pulse", 32'({rise, fall, changed}), 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    sw_raw = 8'h00;
    @(negedge clk);
    chk("post_reset_out",   32'(sw_out), 32'h00);
    chk("post_reset_pulse", 32'({rise, fall, changed}), 32'd0);
    settle("idle_drained");

    // clean step on bit 0
    step(8'h01, 8'h01, 8'h00, 8'h01);
    settle("clean_step_drained");

    // 5-cycle glitch on bit 3 must not commit
    drive(8'h09);
    repeat (4) @(posedge clk);
    drive(8'h01);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("glitch_level", 32'(sw_out), 32'h01);

    // bit 7 bounces every 3 cycles, then settles high
    for (int k = 0; k < 10; k++) begin
      drive((k % 2 == 0) ? 8'h81 : 8'h01);
      repeat (2) @(posedge clk);
    end
    step(8'h81, 8'h80, 8'h00, 8'h81);
    settle("bounce_drained");

    // multi-bit commits
    step(8'h0F, 8'h0E, 8'h80, 8'h0F);
    settle("to_0f_drained");
    step(8'hF0, 8'hF0, 8'h0F, 8'hF0);
    settle("to_f0_drained");
    step(8'h00, 8'h00, 8'hF0, 8'h00);
    settle("to_00_drained");

    // reset while bit 2 is part-way through its window
    drive(8'h04);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    e.rise = 8'h04; e.fall = 8'h00; e.lvl = 8'h04; e.lo = cyc + 11; e.hi = cyc + 14;
    q.push_back(e);
    @(negedge clk);
    chk("mid_reset_out",   32'(sw_out), 32'h00);
    chk("mid_reset_pulse", 32'({rise, fall, changed}), 32'd0);
    settle("mid_reset_drained");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
